// File: rtl/pc_seq_pkg.sv
// pc_sequencer shared types: FSM encoding, opcodes and the DECODE
// branch decision used by the sequencer.
package pc_seq_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_BZ   = 4'hD;

  typedef struct packed {
    logic [2:0] next;
    logic       jump;
  } dec_t;

  function automatic dec_t decode_op(
    input logic [3:0] op,
    input logic       z
  );
    dec_t d;
    d.next = S_EXEC;
    d.jump = 1'b0;
    unique case (1'b1)
      (op == OP_HALT): d.next = S_HALT;
      (op == OP_JMP): begin
        d.next = S_UPDATE;
        d.jump = 1'b1;
      end
      (op == OP_BZ): begin
        d.next = S_UPDATE;
        d.jump = z;
      end
      default: d.next = S_EXEC;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pc_sequencer_fetch_timer.sv
// fetch_timer: counts FETCH cycles spent waiting for an acknowledge and
// flags expiry in the cycle the count reaches MEM_TIMEOUT.
module fetch_timer #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic Clk2,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CW'(MEM_TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk2) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && !clear_i &&
                     (count_d == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute/update control FSM. Emits PC advance
// controls only; the PC arithmetic itself lives in the PC unit.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned OP_W        = 4
) (
  input  logic        Clk2,
  input  logic        reset,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic [15:0] instr,
  input  logic        zero,
  output logic        exec_start,
  input  logic        exec_done,
  output logic        updatePC,
  output logic        jump,
  output logic [11:0] offset,
  output logic [15:0] ir,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  logic [2:0]      state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     retired_q, retired_d;
  logic            fault_q, fault_d;
  logic            jump_q, jump_d;
  logic            fetch_req_q;
  logic            exec_start_q;
  logic            upd_q;
  logic            halted_q;
  logic            expired;
  logic            tmr_clear;
  logic            tmr_en;
  logic [OP_W-1:0] opcode;
  dec_t            dec;

  assign opcode    = ir_q[15 -: OP_W];
  assign tmr_clear = (state_q != S_FETCH);
  assign tmr_en    = (state_q == S_FETCH) && fetch_req_q && !fetch_ack;

  fetch_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .Clk2     (Clk2),
    .reset    (reset),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    jump_d    = 1'b0;
    dec       = decode_op(opcode, zero);
    unique case (state_q)
      S_FETCH: begin
        // an ack only counts once the request is actually on the bus
        if (fetch_req_q && fetch_ack) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (expired) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        state_d = dec.next;
        jump_d  = dec.jump;
      end
      S_EXEC: begin
        if (exec_done) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        retired_d = retired_q + 16'd1;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk2) begin
    if (reset) begin
      state_q      <= S_FETCH;
      ir_q         <= '0;
      retired_q    <= '0;
      fault_q      <= 1'b0;
      jump_q       <= 1'b0;
      fetch_req_q  <= 1'b0;
      exec_start_q <= 1'b0;
      upd_q        <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      retired_q    <= retired_d;
      fault_q      <= fault_d;
      jump_q       <= jump_d;
      fetch_req_q  <= (state_d == S_FETCH);
      exec_start_q <= (state_d == S_EXEC) && (state_q != S_EXEC);
      upd_q        <= (state_d == S_UPDATE);
      halted_q     <= (state_d == S_HALT);
    end
  end

  assign fetch_req  = fetch_req_q;
  assign exec_start = exec_start_q;
  assign updatePC   = upd_q;
  assign jump       = jump_q;
  assign offset     = ir_q[11:0];
  assign ir         = ir_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized memory/datapath driver, instruction-level
// reference model feeding a scoreboard, and directed boundary scenarios.
module tb_pc_sequencer;

  localparam int unsigned TO = 8;

  logic        Clk2 = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req;
  logic        fetch_ack = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        zero = 1'b0;
  logic        exec_start;
  logic        exec_done = 1'b0;
  logic        updatePC;
  logic        jump;
  logic [11:0] offset;
  logic [15:0] ir;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  pc_sequencer #(
    .MEM_TIMEOUT(TO),
    .OP_W       (4)
  ) dut (
    .Clk2      (Clk2),
    .reset     (reset),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .instr     (instr),
    .zero      (zero),
    .exec_start(exec_start),
    .exec_done (exec_done),
    .updatePC  (updatePC),
    .jump      (jump),
    .offset    (offset),
    .ir        (ir),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 Clk2 = ~Clk2;

  typedef struct {
    logic        jump;
    logic [11:0] off;
    logic [15:0] ir;
    logic [15:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          n_es = 0;
  int          m_exec = 0;
  logic [15:0] m_ret = 16'h0;
  logic        prev_es = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // scoreboard monitor
  always @(negedge Clk2) begin
    exp_t e;
    if (!reset) begin
      chk("invariant",
          64'((updatePC || !jump) && (offset == ir[11:0]) &&
              !(halted && (fetch_req || exec_start || updatePC))),
          64'd1);
      if (exec_start) begin
        n_es++;
        chk("exec_start_pulse", 64'(prev_es), 64'd0);
      end
      if (updatePC) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_update", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("upd_jump", 64'(jump), 64'(e.jump));
          chk("upd_offset", 64'(offset), 64'(e.off));
          chk("upd_ir", 64'(ir), 64'(e.ir));
          chk("upd_retired", 64'(retired), 64'(e.ret));
        end
      end
    end
    prev_es = exec_start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1;
    fetch_ack = 1'b0;
    exec_done = 1'b0;
    repeat (3) @(negedge Clk2);
    chk("rst_outs",
        {fetch_req, exec_start, updatePC, jump, halted, fault, ir, retired},
        64'd0);
    exp_q.delete();
    m_ret = 16'h0;
    reset = 1'b0;
    @(negedge Clk2);
    chk("fetch_req_after_rst", 64'(fetch_req), 64'd1);
  endtask

  task automatic run_instr(input logic [15:0] w, input int ackdly,
                           input bit z, input int exdly);
    exp_t       e;
    logic [3:0] op;
    int         n;
    op = w[15:12];
    n = 0;
    while (!fetch_req && n < 10) begin
      @(negedge Clk2);
      n++;
    end
    chk("fetch_req_wait", 64'(fetch_req), 64'd1);
    repeat (ackdly) begin
      exec_done = 1'($urandom);
      @(negedge Clk2);
    end
    fetch_ack = 1'b1;
    instr = w;
    zero = z;
    exec_done = 1'($urandom);
    if (op != 4'hF) begin
      e.jump = (op == 4'hE) || ((op == 4'hD) && z);
      e.off  = w[11:0];
      e.ir   = w;
      e.ret  = m_ret;
      m_ret  = m_ret + 16'd1;
      exp_q.push_back(e);
    end
    @(negedge Clk2);
    fetch_ack = 1'b0;
    instr = 16'($urandom);
    exec_done = 1'($urandom);
    @(negedge Clk2);
    exec_done = 1'b0;
    zero = 1'($urandom);
    if (op == 4'hF) begin
      chk("halt_entry", 64'(halted), 64'd1);
    end else if (op == 4'hE || op == 4'hD) begin
      chk("ctl_update_lat", 64'(updatePC), 64'd1);
    end else begin
      chk("exec_start_lat", 64'(exec_start), 64'd1);
      m_exec++;
      repeat (exdly) @(negedge Clk2);
      exec_done = 1'b1;
      @(negedge Clk2);
      exec_done = 1'b0;
      chk("alu_update_lat", 64'(updatePC), 64'd1);
    end
  endtask

  initial begin
    int n;
    do_reset();

    run_instr(16'h1234, 0, 1'b0, 2);
    @(negedge Clk2);
    chk("retired_after_alu", 64'(retired), 64'd1);
    chk("exec_count_alu", 64'(n_es), 64'd1);

    run_instr(16'hEFFE, 0, 1'b0, 0);
    run_instr(16'hD005, 0, 1'b1, 0);
    run_instr(16'hD005, 0, 1'b0, 0);
    run_instr(16'h2ABC, TO - 1, 1'b1, 0);
    run_instr(16'hE123, TO - 1, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      run_instr({4'($urandom_range(0, 14)), 12'($urandom)},
                int'($urandom_range(0, TO - 1)), 1'($urandom),
                int'($urandom_range(0, 3)));
    end

    @(negedge Clk2);
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    m_ret = 16'hFFFE;
    chk("preload", 64'(retired), 64'hFFFE);
    run_instr(16'hE001, 0, 1'b0, 0);
    run_instr(16'hE001, 0, 1'b0, 0);
    @(negedge Clk2);
    chk("retired_wrap", 64'(retired), 64'h0);

    run_instr(16'hF123, 1, 1'b0, 0);
    repeat (6) begin
      fetch_ack = 1'($urandom);
      exec_done = 1'($urandom);
      @(negedge Clk2);
    end
    chk("halt_absorb", {halted, fetch_req, updatePC, retired}, {3'b100, 16'h0});

    do_reset();
    n = 0;
    while (fetch_req && n < 20) begin
      n++;
      @(negedge Clk2);
    end
    chk("timeout_cycles", 64'(n), 64'(TO));
    chk("timeout_flags", {fault, halted, fetch_req}, 3'b110);
    repeat (10) begin
      exec_done = 1'($urandom);
      @(negedge Clk2);
    end
    chk("timeout_sticky", {fault, halted, fetch_req}, 3'b110);

    do_reset();
    chk("fault_cleared", 64'(fault), 64'd0);
    fetch_ack = 1'b1;
    instr = 16'h3333;
    @(negedge Clk2);
    fetch_ack = 1'b0;
    @(negedge Clk2);
    chk("rst_exec_start", 64'(exec_start), 64'd1);
    m_exec++;
    #1;
    exec_done = 1'b1;
    reset = 1'b1;
    @(negedge Clk2);
    chk("rst_exec_no_upd", {updatePC, retired}, 17'h0);
    exec_done = 1'b0;
    reset = 1'b0;
    @(negedge Clk2);
    chk("rst_exec_resume", 64'(fetch_req), 64'd1);
    run_instr(16'h4001, 0, 1'b0, 0);

    repeat (3) @(negedge Clk2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("exec_start_total", 64'(n_es), 64'(m_exec));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
